// File: rtl/uart_core.sv
// UART transmitter and receiver sharing one free-running 16x oversample tick,
// with an optional internal loopback from o_tx to the receiver input.
module uart_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 921600,
  parameter int D_BITS  = 8,
  parameter int SP_BITS = 1,
  parameter int PARITY  = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_loopback,
  input  logic              i_tx_valid,
  input  logic [D_BITS-1:0] i_tx_data,
  output logic              o_tx_ready,
  output logic              o_tx,
  input  logic              i_rx,
  output logic [D_BITS-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_parity_err,
  output logic              o_frame_err
);
  localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [4:0] MID_LAST  = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] STOP_LAST = 5'(SP_BITS * 16 - 1);
  localparam logic [3:0] DATA_LAST = 4'(D_BITS - 1);
  localparam logic [3:0] SP_LAST   = 4'(SP_BITS - 1);
  localparam logic       HAS_PAR   = (PARITY != 0);
  localparam logic       ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == DW'(DIV - 1));

  // NOTE: sequential state is updated with <= only, so every branch below sees start-of-cycle values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 1'b1;
  end

  state_t            tx_state;
  logic [4:0]        tx_ticks;
  logic [3:0]        tx_bits;
  logic [D_BITS-1:0] tx_shift;
  logic              tx_par;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tx_state   <= S_IDLE;
      tx_ticks   <= '0;
      tx_bits    <= '0;
      tx_shift   <= '0;
      tx_par     <= 1'b0;
      o_tx       <= 1'b1;
      o_tx_ready <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          o_tx       <= 1'b1;
          o_tx_ready <= 1'b1;
          if (i_tx_valid && o_tx_ready) begin
            tx_shift   <= i_tx_data;
            tx_par     <= ^i_tx_data ^ ODD;
            tx_ticks   <= '0;
            o_tx       <= 1'b0;
            o_tx_ready <= 1'b0;
            tx_state   <= S_START;
          end
        end
        S_START: if (tick) begin
          if (tx_ticks == BIT_LAST) begin
            tx_ticks <= '0;
            tx_bits  <= '0;
            o_tx     <= tx_shift[0];
            tx_state <= S_DATA;
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        S_DATA: if (tick) begin
          if (tx_ticks == BIT_LAST) begin
            tx_ticks <= '0;
            tx_shift <= tx_shift >> 1;
            if (tx_bits == DATA_LAST) begin
              o_tx     <= HAS_PAR ? tx_par : 1'b1;
              tx_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              tx_bits <= tx_bits + 4'd1;
              o_tx    <= tx_shift[1];
            end
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        S_PARITY: if (tick) begin
          if (tx_ticks == BIT_LAST) begin
            tx_ticks <= '0;
            o_tx     <= 1'b1;
            tx_state <= S_STOP;
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        S_STOP: if (tick) begin
          if (tx_ticks == STOP_LAST) begin
            tx_ticks   <= '0;
            o_tx_ready <= 1'b1;
            tx_state   <= S_IDLE;
          end else tx_ticks <= tx_ticks + 5'd1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic rx_src, sync0, sync1;

  assign rx_src = i_loopback ? o_tx : i_rx;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= rx_src;
      sync1 <= sync0;
    end
  end

  state_t            rx_state;
  logic [4:0]        rx_ticks;
  logic [3:0]        rx_bits;
  logic [D_BITS-1:0] rx_shift;
  logic              rx_par, rx_ferr, wait_high, par_bad;

  assign par_bad = HAS_PAR && (^rx_shift ^ rx_par ^ ODD);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_state     <= S_IDLE;
      rx_ticks     <= '0;
      rx_bits      <= '0;
      rx_shift     <= '0;
      rx_par       <= 1'b0;
      rx_ferr      <= 1'b0;
      wait_high    <= 1'b0;
      o_rx_data    <= '0;
      o_rx_valid   <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      // NOTE: o_rx_valid defaults low every cycle, so the completion branch alone forms a one-cycle pulse.
      o_rx_valid <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          rx_ticks <= '0;
          if (sync1)           wait_high <= 1'b0;
          else if (!wait_high) rx_state  <= S_START;
        end
        S_START: if (tick) begin
          if (rx_ticks == MID_LAST) begin
            rx_ticks <= '0;
            rx_bits  <= '0;
            rx_state <= sync1 ? S_IDLE : S_DATA;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        S_DATA: if (tick) begin
          if (rx_ticks == BIT_LAST) begin
            rx_ticks <= '0;
            rx_shift <= {sync1, rx_shift[D_BITS-1:1]};
            if (rx_bits == DATA_LAST) begin
              rx_bits  <= '0;
              rx_ferr  <= 1'b0;
              rx_state <= HAS_PAR ? S_PARITY : S_STOP;
            end else rx_bits <= rx_bits + 4'd1;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        S_PARITY: if (tick) begin
          if (rx_ticks == BIT_LAST) begin
            rx_ticks <= '0;
            rx_par   <= sync1;
            rx_state <= S_STOP;
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        S_STOP: if (tick) begin
          if (rx_ticks == BIT_LAST) begin
            rx_ticks <= '0;
            if (rx_bits == SP_LAST) begin
              o_rx_data    <= rx_shift;
              o_rx_valid   <= 1'b1;
              o_parity_err <= par_bad;
              o_frame_err  <= rx_ferr | ~sync1;
              // A low final stop means the line is still low; wait for it to rise.
              wait_high    <= rx_ferr | ~sync1;
              rx_state     <= S_IDLE;
            end else begin
              rx_bits <= rx_bits + 4'd1;
              rx_ferr <= rx_ferr | ~sync1;
            end
          end else rx_ticks <= rx_ticks + 5'd1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: an 8N1 and an 8E2 instance at DIV=2, with
// frames checked bit-by-bit and received words matched against a scoreboard.
module tb_uart_core;
  localparam int CLK_HZ   = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = 2;
  localparam int BIT_CLKS = 16 * DIV;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  logic            i_clk;
  logic            rst_n;
  logic [1:0]      loopback, tx_valid, tx_ready, tx_line, rx_line, rx_valid, perr, ferr;
  logic [1:0][7:0] tx_data, rx_data;

  rx_exp_t exp_q0[$];
  rx_exp_t exp_q1[$];
  rx_exp_t last_rx [2];
  int      vcount [2];
  logic    rec [4096];
  int      errors = 0;
  int      checks = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .D_BITS(8), .SP_BITS(1), .PARITY(0)) dut_a (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_loopback(loopback[0]),
    .i_tx_valid(tx_valid[0]), .i_tx_data(tx_data[0]), .o_tx_ready(tx_ready[0]),
    .o_tx(tx_line[0]), .i_rx(rx_line[0]), .o_rx_data(rx_data[0]),
    .o_rx_valid(rx_valid[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]));

  uart_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .D_BITS(8), .SP_BITS(2), .PARITY(2)) dut_b (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_loopback(loopback[1]),
    .i_tx_valid(tx_valid[1]), .i_tx_data(tx_data[1]), .o_tx_ready(tx_ready[1]),
    .o_tx(tx_line[1]), .i_rx(rx_line[1]), .o_rx_data(rx_data[1]),
    .o_rx_valid(rx_valid[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]));

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Frame model: instance 0 is 8N1, instance 1 is 8 data, even parity, 2 stops.
  function automatic int par_mode(int w);
    return (w == 0) ? 0 : 2;
  endfunction

  function automatic int stop_cnt(int w);
    return (w == 0) ? 1 : 2;
  endfunction

  function automatic int frame_bits(int w);
    return 1 + 8 + ((par_mode(w) != 0) ? 1 : 0) + stop_cnt(w);
  endfunction

  function automatic logic parity_bit(int mode, logic [7:0] d);
    int ones = $countones(d);
    return (mode == 1) ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic frame_bit(int w, logic [7:0] d, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (par_mode(w) != 0 && k == 9) return parity_bit(par_mode(w), d);
    return 1'b1;
  endfunction

  function automatic int qsize(int w);
    return (w == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic push_exp(int w, rx_exp_t e);
    if (w == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic take_valid(int w);
    rx_exp_t e;
    int      n = qsize(w);
    vcount[w]++;
    check($sformatf("rx%0d_pending", w), (n > 0), 1);
    if (n > 0) begin
      if (w == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      last_rx[w] = e;
      check($sformatf("rx%0d_data", w), rx_data[w], e.data);
      check($sformatf("rx%0d_perr", w), perr[w], e.perr);
      check($sformatf("rx%0d_ferr", w), ferr[w], e.ferr);
    end
  endtask

  always @(negedge i_clk) begin
    for (int w = 0; w < 2; w++)
      if (rx_valid[w] === 1'b1) take_valid(w);
  end

  task automatic wait_ready(int w);
    int n = 0;
    while (tx_ready[w] !== 1'b1 && n < 2000) begin
      step();
      n++;
    end
    check($sformatf("tx%0d_ready_wait", w), tx_ready[w], 1);
  endtask

  task automatic wait_drain(int w);
    int n = 0;
    while (qsize(w) != 0 && n < 1000) begin
      step();
      n++;
    end
    check($sformatf("rx%0d_drain", w), qsize(w), 0);
  endtask

  // rec[s] is the first cycle after the handshake; sample each bit at its centre.
  task automatic check_frame(int w, logic [7:0] d, int s);
    int low = 0;
    check($sformatf("tx%0d_start_now", w), rec[s], 0);
    if (d[0]) begin
      while (low < 2 * BIT_CLKS && rec[s+low] == 1'b0) low++;
      check($sformatf("tx%0d_start_len_ok(len=%0d)", w, low),
            (low >= BIT_CLKS - DIV + 1 && low <= BIT_CLKS), 1);
    end
    for (int k = 0; k < frame_bits(w); k++)
      check($sformatf("tx%0d_d%0h_bit%0d", w, d, k),
            rec[s + k*BIT_CLKS + BIT_CLKS/2], frame_bit(w, d, k));
  endtask

  task automatic send_frame(int w, logic [7:0] d);
    rx_exp_t e;
    wait_ready(w);
    tx_data[w]  = d;
    tx_valid[w] = 1'b1;
    step();
    tx_valid[w] = 1'b0;
    tx_data[w]  = 8'($urandom);
    if (loopback[w]) begin
      e.data = d; e.perr = 1'b0; e.ferr = 1'b0;
      push_exp(w, e);
    end
    for (int i = 0; i < frame_bits(w) * BIT_CLKS; i++) begin
      rec[i] = tx_line[w];
      step();
    end
    check_frame(w, d, 0);
    wait_drain(w);
  endtask

  task automatic drive_rx(int w, logic [7:0] d, logic pbit, logic [1:0] stops, logic idle_level);
    rx_exp_t e;
    logic    b;
    int      ones = $countones(d) + int'(pbit);
    int      pw   = (par_mode(w) != 0) ? 1 : 0;
    e.data = d;
    e.perr = (par_mode(w) == 1) ? ((ones % 2) == 0) : (par_mode(w) == 2) ? ((ones % 2) == 1) : 1'b0;
    e.ferr = (stops[0] == 1'b0) || (stop_cnt(w) == 2 && stops[1] == 1'b0);
    push_exp(w, e);
    for (int k = 0; k < frame_bits(w); k++) begin
      if (k == 0)              b = 1'b0;
      else if (k <= 8)         b = d[k-1];
      else if (pw == 1 && k == 9) b = pbit;
      else                     b = stops[k - 9 - pw];
      rx_line[w] = b;
      repeat (BIT_CLKS) step();
    end
    rx_line[w] = idle_level;
    repeat (BIT_CLKS) step();
  endtask

  initial begin
    int   v, vb, hs_n, gap, rdy, idx;
    logic hs;

    rst_n = 1'b0; loopback = 2'b11; tx_valid = '0; rx_line = 2'b11;
    tx_data = '0; vcount[0] = 0; vcount[1] = 0;
    repeat (3) step();
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst%0d_tx", w), tx_line[w], 1);
      check($sformatf("rst%0d_ready", w), tx_ready[w], 0);
      check($sformatf("rst%0d_rx_data", w), rx_data[w], 0);
      check($sformatf("rst%0d_rx_valid", w), rx_valid[w], 0);
      check($sformatf("rst%0d_perr", w), perr[w], 0);
      check($sformatf("rst%0d_ferr", w), ferr[w], 0);
    end
    rst_n = 1'b1;
    step();
    check("rel0_ready", tx_ready[0], 1);
    check("rel1_ready", tx_ready[1], 1);

    // Loopback frames, including the 0xA5 reference frame.
    send_frame(0, 8'hA5);
    repeat (4) send_frame(0, 8'($urandom));
    repeat (3) send_frame(1, 8'($urandom));

    // Valid held high across two words: contiguous frames, ready high one cycle between.
    wait_ready(0);
    begin
      rx_exp_t e;
      e.perr = 1'b0; e.ferr = 1'b0;
      e.data = 8'h11; push_exp(0, e);
      e.data = 8'h22; push_exp(0, e);
    end
    tx_data[0] = 8'h11; tx_valid[0] = 1'b1;
    hs_n = 0; gap = 0; rdy = 0; idx = 0;
    for (int i = 0; i < 2000 && idx < 2 * 10 * BIT_CLKS + 40; i++) begin
      hs = tx_valid[0] & tx_ready[0];
      step();
      if (hs) begin
        hs_n++;
        if (hs_n == 1) tx_data[0] = 8'h22;
        else begin
          tx_valid[0] = 1'b0;
          tx_data[0]  = 8'($urandom);
          gap = idx;
        end
      end
      if (hs_n >= 1) begin
        if (hs_n == 1 && tx_ready[0]) rdy++;
        rec[idx] = tx_line[0];
        idx++;
      end
    end
    check("b2b_handshakes", hs_n, 2);
    check("b2b_ready_cycles", rdy, 1);
    check($sformatf("b2b_gap_ok(gap=%0d)", gap),
          (gap >= 10*BIT_CLKS - DIV + 2 && gap <= 10*BIT_CLKS + 1), 1);
    check_frame(0, 8'h11, 0);
    check_frame(0, 8'h22, gap);
    wait_drain(0);

    // Direct-driven frames on the 8E2 receiver, parity and stop variants.
    loopback[1] = 1'b0;
    repeat (8) step();
    drive_rx(1, 8'h03, 1'b1, 2'b11, 1'b1);
    wait_drain(1);
    drive_rx(1, 8'h03, 1'b0, 2'b11, 1'b1);
    wait_drain(1);
    for (int i = 0; i < 6; i++) begin
      logic [1:0] st = (i % 3 == 0) ? 2'($urandom) : 2'b11;
      drive_rx(1, 8'($urandom), 1'($urandom), st, 1'b1);
      wait_drain(1);
    end

    // Second stop low and line held low: no new frame until the line rises.
    v = vcount[1];
    drive_rx(1, 8'h5C, parity_bit(2, 8'h5C), 2'b01, 1'b0);
    wait_drain(1);
    repeat (500) step();
    check("ferr_hold_low_no_frame", vcount[1], v + 1);
    rx_line[1] = 1'b1;
    repeat (2 * BIT_CLKS) step();
    drive_rx(1, 8'hC3, parity_bit(2, 8'hC3), 2'b11, 1'b1);
    wait_drain(1);

    // 8N1 receiver: good frame, low stop bit, then a 6-clock glitch.
    loopback[0] = 1'b0;
    repeat (8) step();
    drive_rx(0, 8'($urandom), 1'b0, 2'b11, 1'b1);
    wait_drain(0);
    drive_rx(0, 8'h96, 1'b0, 2'b10, 1'b1);
    wait_drain(0);
    v = vcount[0];
    rx_line[0] = 1'b0;
    repeat (6) step();
    rx_line[0] = 1'b1;
    repeat (500) step();
    check("glitch_no_valid", vcount[0], v);
    check("glitch_data_held", rx_data[0], last_rx[0].data);
    check("glitch_perr_held", perr[0], last_rx[0].perr);
    check("glitch_ferr_held", ferr[0], last_rx[0].ferr);

    // One-cycle reset in the middle of a loopback data bit.
    loopback[0] = 1'b1;
    repeat (8) step();
    wait_ready(0);
    v = vcount[0]; vb = vcount[1];
    tx_data[0] = 8'($urandom) | 8'h01; tx_valid[0] = 1'b1;
    step();
    tx_valid[0] = 1'b0;
    repeat (4 * BIT_CLKS + BIT_CLKS/2) step();
    rst_n = 1'b0;
    step();
    check("midrst_tx", tx_line[0], 1);
    check("midrst_ready", tx_ready[0], 0);
    check("midrst_rx_data0", rx_data[0], 0);
    check("midrst_rx_data1", rx_data[1], 0);
    check("midrst_perr1", perr[1], 0);
    check("midrst_ferr0", ferr[0], 0);
    rst_n = 1'b1;
    step();
    check("midrst_ready_after", tx_ready[0], 1);
    repeat (600) step();
    check("midrst_no_valid0", vcount[0], v);
    check("midrst_no_valid1", vcount[1], vb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
